// File: rtl/tail_light_pkg.sv
// Shared types and helpers for the tail-light sequencer: mode encoding,
// default lamp count and the thermometer decode.
package tail_light_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } mode_e;

  localparam int LAMPS_DEF = 3;

  // Lower p bits set; sized for the widest legal lamp count (8).
  function automatic logic [7:0] therm(input logic [3:0] p);
    logic [7:0] t;
    for (int i = 0; i < 8; i++) begin
      t[i] = (i < int'(p));
    end
    return t;
  endfunction

endpackage

// File: rtl/tail_light_sequencer_edge_detect_rise.sv
// Rising-edge detector for a signal already in the clock domain; the history
// bit's reset value decides whether a level high at reset release counts.
module edge_detect_rise #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic sig_i,
  output logic rise_o
);

  logic hist_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      hist_q <= RST_VAL;
    end else begin
      hist_q <= sig_i;
    end
  end

  assign rise_o = sig_i & ~hist_q;

endmodule

// File: rtl/tail_light_sequencer.sv
// Tail-light sequencer: thermometer turn sequence, hazard blink and brake
// overlay, advanced one step per rising edge of the slow divider output.
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter  int LAMPS   = LAMPS_DEF,
  localparam int PHASE_W = $clog2(LAMPS + 1)
) (
  input  logic             inClock,
  input  logic             reset,
  input  logic             slowClock,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] lightsL,
  output logic [LAMPS-1:0] lightsR,
  output logic             busy
);

  localparam logic [PHASE_W-1:0] LAMPS_P = PHASE_W'(LAMPS);
  localparam logic [PHASE_W-1:0] ONE_P   = PHASE_W'(1);

  logic               step;
  mode_e              mode_q, mode_d, req;
  logic [PHASE_W-1:0] phase_q, phase_d;
  logic [LAMPS-1:0]   lights_l_q, lights_l_d;
  logic [LAMPS-1:0]   lights_r_q, lights_r_d;
  logic               busy_q, busy_d;
  logic [7:0]         therm_full;
  logic [LAMPS-1:0]   therm_v;
  logic [LAMPS-1:0]   brk_v;

  // History starts high so a slowClock already high at release is not a step.
  edge_detect_rise #(.RST_VAL(1'b1)) u_step (
    .clk_i  (inClock),
    .rst_ni (reset),
    .sig_i  (slowClock),
    .rise_o (step)
  );

  always_comb begin
    req = IDLE;
    if (hazard || (left && right)) begin
      req = HAZ;
    end else if (left) begin
      req = LEFT;
    end else if (right) begin
      req = RIGHT;
    end
  end

  always_comb begin
    mode_d  = mode_q;
    phase_d = phase_q;
    if (step) begin
      unique case (mode_q)
        IDLE: begin
          if (req != IDLE) begin
            mode_d  = req;
            phase_d = ONE_P;
          end
        end
        LEFT, RIGHT: begin
          if (req == HAZ) begin
            mode_d  = HAZ;
            phase_d = ONE_P;
          end else if (req == mode_q) begin
            // Full bar is followed by one all-off step before restarting.
            phase_d = (phase_q == LAMPS_P) ? '0 : phase_q + ONE_P;
          end else begin
            mode_d  = IDLE;
            phase_d = '0;
          end
        end
        HAZ: begin
          if (req == HAZ) begin
            phase_d = (phase_q == '0) ? ONE_P : '0;
          end else begin
            mode_d  = IDLE;
            phase_d = '0;
          end
        end
        default: begin
          mode_d  = IDLE;
          phase_d = '0;
        end
      endcase
    end
  end

  always_comb begin
    therm_full = therm(4'(phase_d));
    therm_v    = therm_full[LAMPS-1:0];
    brk_v      = brake ? '1 : '0;
    lights_l_d = brk_v;
    lights_r_d = brk_v;
    unique case (mode_d)
      LEFT:    lights_l_d = therm_v;
      RIGHT:   lights_r_d = therm_v;
      HAZ: begin
        lights_l_d = (phase_d != '0) ? '1 : '0;
        lights_r_d = (phase_d != '0) ? '1 : '0;
      end
      default: ;
    endcase
    busy_d = (mode_d != IDLE);
  end

  always_ff @(posedge inClock or negedge reset) begin
    if (!reset) begin
      mode_q     <= IDLE;
      phase_q    <= '0;
      lights_l_q <= '0;
      lights_r_q <= '0;
      busy_q     <= 1'b0;
    end else begin
      mode_q     <= mode_d;
      phase_q    <= phase_d;
      lights_l_q <= lights_l_d;
      lights_r_q <= lights_r_d;
      busy_q     <= busy_d;
    end
  end

  assign lightsL = lights_l_q;
  assign lightsR = lights_r_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Self-checking bench for tail_light_sequencer: directed scenarios plus a
// randomized run, all compared against a behavioural model of the lamp rules.
module tb_tail_light_sequencer;

  localparam int LAMPS = 3;
  localparam int ALLON = (1 << LAMPS) - 1;

  logic             inClock = 1'b0;
  logic             reset = 1'b0;
  logic             slowClock = 1'b0;
  logic             left = 1'b0;
  logic             right = 1'b0;
  logic             hazard = 1'b0;
  logic             brake = 1'b0;
  logic [LAMPS-1:0] lightsL;
  logic [LAMPS-1:0] lightsR;
  logic             busy;

  int checks = 0;
  int errors = 0;

  // Model state: mode 0=idle 1=left 2=right 3=hazard, phase 0..LAMPS.
  int               m_mode = 0;
  int               m_phase = 0;
  bit               m_prev = 1'b1;
  logic [LAMPS-1:0] exp_l = '0;
  logic [LAMPS-1:0] exp_r = '0;
  logic             exp_busy = 1'b0;

  tail_light_sequencer #(.LAMPS(LAMPS)) dut (
    .inClock   (inClock),
    .reset     (reset),
    .slowClock (slowClock),
    .left      (left),
    .right     (right),
    .hazard    (hazard),
    .brake     (brake),
    .lightsL   (lightsL),
    .lightsR   (lightsR),
    .busy      (busy)
  );

  always #10 inClock = ~inClock;

  task automatic model_reset();
    m_mode = 0; m_phase = 0; m_prev = 1'b1;
    exp_l = '0; exp_r = '0; exp_busy = 1'b0;
  endtask

  // Advance one clock; the model consumes the inputs present before the edge.
  task automatic cyc();
    int nm, np, rq, brk, bar;
    bit st;
    st = slowClock && !m_prev;
    nm = m_mode;
    np = m_phase;
    if (st) begin
      if (hazard || (left && right)) rq = 3;
      else if (left) rq = 1;
      else if (right) rq = 2;
      else rq = 0;
      if (m_mode == 0) begin
        if (rq != 0) begin nm = rq; np = 1; end
      end else if (m_mode == 3) begin
        if (rq == 3) np = (m_phase == 0) ? 1 : 0;
        else begin nm = 0; np = 0; end
      end else begin
        if (rq == 3) begin nm = 3; np = 1; end
        else if (rq == m_mode) np = (m_phase == LAMPS) ? 0 : m_phase + 1;
        else begin nm = 0; np = 0; end
      end
    end
    brk = brake ? ALLON : 0;
    bar = (1 << np) - 1;
    @(posedge inClock);
    #1;
    if (!reset) begin
      model_reset();
    end else begin
      m_prev  = slowClock;
      m_mode  = nm;
      m_phase = np;
      exp_busy = (nm != 0);
      case (nm)
        1: begin exp_l = LAMPS'(bar); exp_r = LAMPS'(brk); end
        2: begin exp_r = LAMPS'(bar); exp_l = LAMPS'(brk); end
        3: begin exp_l = (np != 0) ? LAMPS'(ALLON) : '0; exp_r = exp_l; end
        default: begin exp_l = LAMPS'(brk); exp_r = LAMPS'(brk); end
      endcase
    end
  endtask

  // One slowClock rise: a low cycle then a high cycle (step taken on the latter).
  task automatic do_step();
    slowClock = 1'b0;
    cyc();
    slowClock = 1'b1;
    cyc();
  endtask

  task automatic do_reset();
    left = 0; right = 0; hazard = 0; brake = 0; slowClock = 1'b0;
    reset = 1'b0;
    model_reset();
    cyc();
    reset = 1'b1;
    cyc();
  endtask

  task automatic test_reset();
    slowClock = 1'b1;
    reset = 1'b0;
    model_reset();
    cyc();
    checks++;
    if (lightsL !== 3'b000 || lightsR !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: L=%b R=%b busy=%b required L=000 R=000 busy=0", lightsL, lightsR, busy);
    end
    reset = 1'b1;
    left = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc();
      checks++;
      if (lightsL !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_no_step: cycle %0d L=%b busy=%b required L=000 busy=0", i, lightsL, busy);
      end
    end
    do_step();
    checks++;
    if (lightsL !== 3'b001 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_fresh_rise: L=%b busy=%b required L=001 busy=1", lightsL, busy);
    end
    left = 1'b0;
  endtask

  task automatic test_left_seq();
    logic [LAMPS-1:0] want [5] = '{3'b001, 3'b011, 3'b111, 3'b000, 3'b001};
    do_reset();
    left = 1'b1;
    for (int i = 0; i < 5; i++) begin
      do_step();
      checks++;
      if (lightsL !== want[i] || lightsR !== 3'b000 || lightsL !== exp_l) begin
        errors++;
        $display("FAIL left_seq: step %0d L=%b R=%b required L=%b R=000", i, lightsL, lightsR, want[i]);
      end
    end
  endtask

  task automatic test_right_brake();
    logic [LAMPS-1:0] want [3] = '{3'b001, 3'b011, 3'b111};
    do_reset();
    right = 1'b1;
    brake = 1'b1;
    for (int i = 0; i < 3; i++) begin
      do_step();
      checks++;
      if (lightsR !== want[i] || lightsL !== 3'b111) begin
        errors++;
        $display("FAIL right_brake: step %0d R=%b L=%b required R=%b L=111", i, lightsR, lightsL, want[i]);
      end
    end
    brake = 1'b0;
    cyc();
    checks++;
    if (lightsL !== 3'b000 || lightsR !== 3'b111) begin
      errors++;
      $display("FAIL brake_release: L=%b R=%b required L=000 R=111", lightsL, lightsR);
    end
  endtask

  task automatic test_hazard_preempt();
    do_reset();
    left = 1'b1;
    do_step();
    do_step();
    hazard = 1'b1;
    do_step();
    checks++;
    if (lightsL !== 3'b111 || lightsR !== 3'b111 || busy !== 1'b1) begin
      errors++;
      $display("FAIL haz_on: L=%b R=%b busy=%b required L=111 R=111 busy=1", lightsL, lightsR, busy);
    end
    hazard = 1'b0;
    right = 1'b1;
    do_step();
    checks++;
    if (lightsL !== 3'b000 || lightsR !== 3'b000 || busy !== 1'b1) begin
      errors++;
      $display("FAIL haz_blink_off: L=%b R=%b busy=%b required L=000 R=000 busy=1", lightsL, lightsR, busy);
    end
    brake = 1'b1;
    do_step();
    checks++;
    if (lightsL !== 3'b111 || lightsR !== 3'b111) begin
      errors++;
      $display("FAIL haz_blink_on: L=%b R=%b required L=111 R=111", lightsL, lightsR);
    end
    brake = 1'b0;
    left = 1'b0;
    right = 1'b0;
  endtask

  task automatic test_drop();
    do_reset();
    left = 1'b1;
    do_step();
    do_step();
    left = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (lightsL !== 3'b011 || busy !== 1'b1) begin
        errors++;
        $display("FAIL drop_hold: cycle %0d L=%b busy=%b required L=011 busy=1", i, lightsL, busy);
      end
    end
    do_step();
    checks++;
    if (lightsL !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL drop_idle: L=%b busy=%b required L=000 busy=0", lightsL, busy);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    right = 1'b1;
    do_step();
    do_step();
    #3;
    reset = 1'b0;
    #1;
    checks++;
    if (lightsR !== 3'b000 || lightsL !== 3'b000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: L=%b R=%b busy=%b required all 0", lightsL, lightsR, busy);
    end
    model_reset();
    cyc();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++;
      if (lightsR !== 3'b000 || busy !== 1'b0) begin
        errors++;
        $display("FAIL reset_mid_wait: cycle %0d R=%b busy=%b required R=000 busy=0", i, lightsR, busy);
      end
    end
    do_step();
    checks++;
    if (lightsR !== 3'b001) begin
      errors++;
      $display("FAIL reset_mid_resume: R=%b required 001", lightsR);
    end
    right = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0) slowClock = ~slowClock;
      if ($urandom_range(0, 15) == 0) left = $urandom_range(0, 1);
      if ($urandom_range(0, 15) == 0) right = $urandom_range(0, 1);
      if ($urandom_range(0, 31) == 0) hazard = $urandom_range(0, 1);
      if ($urandom_range(0, 7) == 0) brake = $urandom_range(0, 1);
      cyc();
      checks++;
      if (lightsL !== exp_l || lightsR !== exp_r || busy !== exp_busy) begin
        errors++;
        $display("FAIL random: cycle %0d L=%b R=%b busy=%b required L=%b R=%b busy=%b",
                 i, lightsL, lightsR, busy, exp_l, exp_r, exp_busy);
      end
    end
  endtask

  initial begin
    test_reset();
    test_left_seq();
    test_right_brake();
    test_hazard_preempt();
    test_drop();
    test_reset_mid();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tail_light_sequencer.md
Name: tail_light_sequencer

Overview:
- Tail-light controller that sits directly downstream of the team's slow-clock divider (2 Hz square wave).
- Runs entirely on the fast system clock. The divider output comes in as a data signal; each rising edge of it is one sequencing step.
- Drives LAMPS lamps per side: thermometer turn sequence, hazard blink, and a brake overlay.

Parameters:
- LAMPS, 3, lamps per side (legal range 1..8); bit 0 is the innermost lamp.
- PHASE_W, $clog2(LAMPS+1), width of the phase counter (derived; not to be overridden).

Ports:
- inClock  input  1  system clock (50 MHz), the only clock.
- reset  input  1  asynchronous, active-low reset.
- slowClock  input  1  divider output, synchronous to inClock; each rising edge is one step.
- left  input  1  left turn request, level.
- right  input  1  right turn request, level.
- hazard  input  1  hazard request, level.
- brake  input  1  brake pedal, level.
- lightsL  output  LAMPS  left lamp drive, registered.
- lightsR  output  LAMPS  right lamp drive, registered.
- busy  output  1  high when the mode is not IDLE, registered.

Behaviour:
- Reset (reset=0, asynchronous):
  - lightsL=0, lightsR=0, busy=0.
  - mode=IDLE, phase=0.
  - slowClock history register=1, so a slowClock that is already high at reset release gives no step.
- Step detection:
  - step = slowClock & ~slowClock_q, where slowClock_q is slowClock registered on inClock.
  - step is high for exactly one inClock cycle per rising edge of slowClock.
  - No synchroniser is used; slowClock is already in the inClock domain.
- State: mode ∈ {IDLE, LEFT, RIGHT, HAZ}, plus phase 0..LAMPS.
- Updates: mode and phase change only on cycles where step=1. The mode decision uses the levels of left, right and hazard sampled in that cycle.
- Requests, highest priority first:
  - hazard=1, or left=1 and right=1 together → HAZ request.
  - left=1 → LEFT request.
  - right=1 → RIGHT request.
  - otherwise no request.
- Transitions on step:
  - IDLE:
    - HAZ request → HAZ, phase=1.
    - LEFT request → LEFT, phase=1.
    - RIGHT request → RIGHT, phase=1.
    - no request → stay in IDLE.
  - LEFT or RIGHT:
    - HAZ request → HAZ, phase=1 (pre-empts mid-sequence).
    - request for the same side:
      - phase<LAMPS → phase+1.
      - phase==LAMPS → phase=0 and mode stays (all-off gap), then phase=1 on the next step.
    - request for the other side, or no request → IDLE, phase=0.
  - HAZ:
    - HAZ request still present → phase toggles 1↔0 (blink).
    - otherwise → IDLE, phase=0.
- Lamp decode, thermometer: therm(p) = lower p bits set.
  - LEFT: lightsL=therm(phase); lightsR = brake ? all-ones : 0.
  - RIGHT: lightsR=therm(phase); lightsL = brake ? all-ones : 0.
  - HAZ: both sides = phase ? all-ones : 0; brake is ignored.
  - IDLE: both sides = brake ? all-ones : 0.
- Output timing:
  - Outputs are registered from next-state values and brake.
  - A slowClock rise seen in cycle n gives new lamps after the inClock edge ending cycle n (latency 1 edge).
  - A brake change also has 1-edge latency and needs no step.
- Deasserting a turn request mid-sequence takes effect at the next step, not immediately.
- Reset asserted mid-sequence: all outputs go to 0 immediately (asynchronous). After release, the block waits for a fresh slowClock rise.

Decomposition:
- Shared package tail_light_pkg holds:
  - the mode enum (IDLE=2'd0, LEFT=2'd1, RIGHT=2'd2, HAZ=2'd3);
  - the therm() function;
  - the LAMPS default.
- One sub-module, edge_detect_rise: a registered history bit with a configurable reset value, used for step generation.

Test Plan:
- Reset with slowClock held at 1, then release with no stimulus → lights stay 0 and busy=0 until slowClock falls and rises again.
- left=1, LAMPS=3, 5 slowClock rises → lightsL goes 001, 011, 111, 000, 001 (one value per step, each 1 inClock after the rise); lightsR=000 throughout.
- right=1, brake=1, 3 rises → lightsR 001, 011, 111; lightsL=111 throughout; left lamps return to 000 one edge after brake=0.
- left=1 until lightsL=011, then hazard=1 for 1 step → both sides 111 at that step; next step both 000; left=right=1 with hazard=0 keeps the blink going.
- left=1 at lightsL=011, then left dropped between rises → lightsL stays 011 until the next rise, then 000; busy=0.
- reset pulsed low during RIGHT phase 2 → lights 0 within the same cycle (asynchronous); no step is taken until a new rise after release.
